// File: rtl/uart_pkg.sv
// Shared types and default parameters for the UART TX arbiter.
// States and defaults live here so the top and bench agree on them.
package uart_pkg;

  localparam int NREQ_DEF      = 4;
  localparam int DW_DEF        = 8;
  localparam int MAX_BURST_DEF = 16;
  localparam int ACK_TMO_DEF   = 3;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE
  } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin pick: first request after ptr wins, wrapping.
// Pure combinational; one-hot gnt, all-zero when req is empty.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= N; i++) begin
      idx = PW'((int'(ptr) + i) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates byte streams from NREQ requesters onto one UART TX,
// with per-grant burst limit and an ack timeout on TX_BUSY.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ      = NREQ_DEF,
  parameter int DW        = DW_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF,
  parameter int ACK_TMO   = ACK_TMO_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [NREQ-1:0]    REQ_VALID,
  input  logic [NREQ*DW-1:0] REQ_DATA,
  input  logic [NREQ-1:0]    REQ_LAST,
  output logic [NREQ-1:0]    REQ_READY,
  input  logic             TX_BUSY,
  output logic [DW-1:0]    TX_DATA,
  output logic             TX_DATA_VALID,
  output logic [NREQ-1:0]  GRANT,
  output logic             ARB_BUSY,
  output logic             ERR_TMO
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int TW = (ACK_TMO > 1) ? $clog2(ACK_TMO) : 1;

  arb_state_t      state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [PW-1:0]   lown_q, lown_d;
  logic [BW-1:0]   burst_q, burst_d;
  logic            last_q, last_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [DW-1:0]   txd_q, txd_d;
  logic            txv_q, txv_d;
  logic [NREQ-1:0] rdy_q, rdy_d;
  logic            err_q, err_d;

  logic [NREQ-1:0] pick_gnt;
  logic [PW-1:0]   pick_idx;
  logic [DW-1:0]   own_data;

  rr_pick #(.N(NREQ), .PW(PW)) u_pick (
    .req (REQ_VALID),
    .ptr (lown_q),
    .gnt (pick_gnt)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NREQ; i++)
      if (pick_gnt[i]) pick_idx = PW'(i);
  end

  assign own_data = REQ_DATA[int'(owner_q)*DW +: DW];

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    lown_d  = lown_q;
    burst_d = burst_q;
    last_d  = last_q;
    tmo_d   = tmo_q;
    txd_d   = txd_q;
    txv_d   = 1'b0;
    rdy_d   = '0;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (|REQ_VALID) begin
          grant_d = pick_gnt;
          owner_d = pick_idx;
          burst_d = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (!REQ_VALID[owner_q]) begin
          grant_d = '0;
          lown_d  = owner_q;
          state_d = IDLE;
        end else if (!TX_BUSY) begin
          txv_d   = 1'b1;
          rdy_d   = grant_q;
          txd_d   = own_data;
          last_d  = REQ_LAST[owner_q];
          tmo_d   = '0;
          state_d = WAIT_ACK;
          if (burst_q != BW'(MAX_BURST))
            burst_d = burst_q + BW'(1);
        end
      end
      WAIT_ACK: begin
        if (TX_BUSY) begin
          state_d = WAIT_DONE;
        end else if (tmo_q == TW'(ACK_TMO - 1)) begin
          err_d   = 1'b1;
          grant_d = '0;
          lown_d  = owner_q;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      WAIT_DONE: begin
        if (!TX_BUSY) begin
          if (last_q || burst_q == BW'(MAX_BURST)) begin
            grant_d = '0;
            lown_d  = owner_q;
            state_d = IDLE;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      lown_q  <= PW'(NREQ - 1);
      burst_q <= '0;
      last_q  <= 1'b0;
      tmo_q   <= '0;
      txd_q   <= '0;
      txv_q   <= 1'b0;
      rdy_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      lown_q  <= lown_d;
      burst_q <= burst_d;
      last_q  <= last_d;
      tmo_q   <= tmo_d;
      txd_q   <= txd_d;
      txv_q   <= txv_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
    end
  end

  assign GRANT         = grant_q;
  assign REQ_READY     = rdy_q;
  assign TX_DATA       = txd_q;
  assign TX_DATA_VALID = txv_q;
  assign ARB_BUSY      = (state_q != IDLE);
  assign ERR_TMO       = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with requester and UART TX models.
// Models act on the falling edge; the DUT acts on the rising edge.
module tb_uart_tx_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [3:0]  REQ_VALID = '0;
  logic [31:0] REQ_DATA = '0;
  logic [3:0]  REQ_LAST = '0;
  logic [3:0]  REQ_READY;
  logic        TX_BUSY = 1'b0;
  logic [7:0]  TX_DATA;
  logic        TX_DATA_VALID;
  logic [3:0]  GRANT;
  logic        ARB_BUSY;
  logic        ERR_TMO;

  int n_cmp = 0;
  int n_bad = 0;

  int         rq_len [4];
  int         rq_pos [4];
  logic [7:0] rq_base [4];

  int         log_n = 0;
  logic [7:0] log_d [64];
  logic [3:0] log_g [64];

  int tx_mode = 0;
  int tx_hold = 10;
  int tx_left = 0;
  bit tx_pend = 0;

  uart_tx_arbiter #(
    .NREQ(4), .DW(8), .MAX_BURST(16), .ACK_TMO(3)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .REQ_VALID     (REQ_VALID),
    .REQ_DATA      (REQ_DATA),
    .REQ_LAST      (REQ_LAST),
    .REQ_READY     (REQ_READY),
    .TX_BUSY       (TX_BUSY),
    .TX_DATA       (TX_DATA),
    .TX_DATA_VALID (TX_DATA_VALID),
    .GRANT         (GRANT),
    .ARB_BUSY      (ARB_BUSY),
    .ERR_TMO       (ERR_TMO)
  );

  always #5 CLK = ~CLK;

  // requester, TX and strobe-logging models
  initial begin
    for (int i = 0; i < 4; i++) begin
      rq_len[i] = 0; rq_pos[i] = 0; rq_base[i] = '0;
    end
    forever begin
      @(negedge CLK);
      for (int i = 0; i < 4; i++)
        if (REQ_READY[i] && rq_pos[i] < rq_len[i]) rq_pos[i]++;
      if (TX_DATA_VALID && log_n < 64) begin
        log_d[log_n] = TX_DATA;
        log_g[log_n] = GRANT;
        log_n++;
      end
      if (tx_pend) begin
        TX_BUSY = 1'b1; tx_left = tx_hold; tx_pend = 0;
      end else if (tx_left > 0) begin
        tx_left--;
        if (tx_left == 0) TX_BUSY = 1'b0;
      end
      if (TX_DATA_VALID && tx_mode == 0) tx_pend = 1;
      for (int i = 0; i < 4; i++) begin
        REQ_VALID[i] = rq_pos[i] < rq_len[i];
        REQ_DATA[i*8 +: 8] = 8'(int'(rq_base[i]) + rq_pos[i]);
        REQ_LAST[i] = REQ_VALID[i] && (rq_pos[i] == rq_len[i] - 1);
      end
    end
  end

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic load(input int i, input logic [7:0] b, input int n);
    rq_base[i] = b;
    rq_pos[i]  = 0;
    rq_len[i]  = n;
  endtask

  task automatic wait_strobes(input int n, output bit ok);
    ok = 0;
    for (int t = 0; t < 2000 && !ok; t++) begin
      tick();
      if (log_n >= n) ok = 1;
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 0;
    for (int t = 0; t < 500 && !ok; t++) begin
      tick();
      if (!ARB_BUSY && !TX_BUSY && REQ_VALID == 4'b0) ok = 1;
    end
  endtask

  task automatic test_reset();
    RST = 1'b0;
    repeat (3) tick();
    n_cmp++; if (GRANT !== 4'b0) begin n_bad++;
      $display("FAIL reset_grant got %b want 0000", GRANT); end
    n_cmp++; if (REQ_READY !== 4'b0) begin n_bad++;
      $display("FAIL reset_ready got %b want 0000", REQ_READY); end
    n_cmp++; if (TX_DATA !== 8'h00) begin n_bad++;
      $display("FAIL reset_txdata got %h want 00", TX_DATA); end
    n_cmp++; if (TX_DATA_VALID !== 1'b0) begin n_bad++;
      $display("FAIL reset_txv got %b want 0", TX_DATA_VALID); end
    n_cmp++; if (ARB_BUSY !== 1'b0) begin n_bad++;
      $display("FAIL reset_busy got %b want 0", ARB_BUSY); end
    n_cmp++; if (ERR_TMO !== 1'b0) begin n_bad++;
      $display("FAIL reset_err got %b want 0", ERR_TMO); end
    RST = 1'b1;
    tick();
  endtask

  task automatic test_latency();
    int k;
    bit ok;
    log_n = 0;
    load(0, 8'h55, 1);
    tick();
    k = 0;
    while (!TX_DATA_VALID && k < 10) begin
      tick(); k++;
    end
    n_cmp++; if (k !== 2) begin n_bad++;
      $display("FAIL latency got %0d want 2", k); end
    n_cmp++; if (TX_DATA !== 8'h55) begin n_bad++;
      $display("FAIL latency_data got %h want 55", TX_DATA); end
    n_cmp++; if (REQ_READY !== 4'b0001) begin n_bad++;
      $display("FAIL latency_ready got %b want 0001", REQ_READY); end
    wait_idle(ok);
    n_cmp++; if (!ok) begin n_bad++;
      $display("FAIL latency_idle got timeout want idle"); end
  endtask

  task automatic test_single_frame();
    bit ok;
    logic [7:0] e;
    log_n = 0;
    load(1, 8'hA1, 3);
    wait_strobes(3, ok);
    n_cmp++; if (!ok) begin n_bad++;
      $display("FAIL frame_strobes got %0d want 3", log_n); end
    for (int k = 0; k < 3; k++) begin
      e = 8'(8'hA1 + k);
      n_cmp++; if (log_d[k] !== e) begin n_bad++;
        $display("FAIL frame_data%0d got %h want %h", k, log_d[k], e); end
      n_cmp++; if (log_g[k] !== 4'b0010) begin n_bad++;
        $display("FAIL frame_grant%0d got %b want 0010", k, log_g[k]); end
    end
    wait_idle(ok);
    n_cmp++; if (!ok || GRANT !== 4'b0) begin n_bad++;
      $display("FAIL frame_release got %b want 0000", GRANT); end
    n_cmp++; if (log_n !== 3) begin n_bad++;
      $display("FAIL frame_count got %0d want 3", log_n); end
  endtask

  task automatic test_rr_all();
    bit ok;
    logic [3:0] eg;
    RST = 1'b0; tick(); RST = 1'b1; tick();
    log_n = 0;
    for (int i = 0; i < 4; i++) load(i, 8'(8'h10 + i), 1);
    wait_strobes(4, ok);
    n_cmp++; if (!ok) begin n_bad++;
      $display("FAIL rr_strobes got %0d want 4", log_n); end
    for (int k = 0; k < 4; k++) begin
      eg = 4'(1 << k);
      n_cmp++; if (log_g[k] !== eg) begin n_bad++;
        $display("FAIL rr_grant%0d got %b want %b", k, log_g[k], eg); end
      n_cmp++; if (log_d[k] !== 8'(8'h10 + k)) begin n_bad++;
        $display("FAIL rr_data%0d got %h want %h", k, log_d[k], 8'(8'h10 + k)); end
    end
    wait_idle(ok);
    load(0, 8'h20, 1);
    wait_strobes(5, ok);
    n_cmp++; if (!ok || log_g[4] !== 4'b0001) begin n_bad++;
      $display("FAIL rr_again got %b want 0001", log_g[4]); end
    wait_idle(ok);
  endtask

  task automatic test_burst();
    bit ok;
    logic [3:0] eg;
    logic [7:0] ed;
    log_n = 0;
    load(2, 8'h80, 20);
    load(3, 8'hC0, 1);
    wait_strobes(21, ok);
    n_cmp++; if (!ok) begin n_bad++;
      $display("FAIL burst_strobes got %0d want 21", log_n); end
    for (int k = 0; k < 21; k++) begin
      if (k < 16) begin eg = 4'b0100; ed = 8'(8'h80 + k); end
      else if (k == 16) begin eg = 4'b1000; ed = 8'hC0; end
      else begin eg = 4'b0100; ed = 8'(8'h80 + k - 1); end
      n_cmp++; if (log_g[k] !== eg || log_d[k] !== ed) begin n_bad++;
        $display("FAIL burst%0d got %b/%h want %b/%h",
                 k, log_g[k], log_d[k], eg, ed); end
    end
    wait_idle(ok);
    n_cmp++; if (!ok || ERR_TMO !== 1'b0) begin n_bad++;
      $display("FAIL burst_end got err=%b want 0", ERR_TMO); end
  endtask

  task automatic test_drop();
    bit ok;
    log_n = 0;
    load(0, 8'h50, 3);
    wait_strobes(1, ok);
    rq_len[0] = 0;
    load(1, 8'h60, 1);
    wait_strobes(2, ok);
    n_cmp++; if (!ok || log_g[0] !== 4'b0001 || log_d[0] !== 8'h50) begin
      n_bad++;
      $display("FAIL drop_first got %b/%h want 0001/50", log_g[0], log_d[0]); end
    n_cmp++; if (log_g[1] !== 4'b0010 || log_d[1] !== 8'h60) begin
      n_bad++;
      $display("FAIL drop_next got %b/%h want 0010/60", log_g[1], log_d[1]); end
    wait_idle(ok);
    n_cmp++; if (!ok || ERR_TMO !== 1'b0 || log_n !== 2) begin n_bad++;
      $display("FAIL drop_end got err=%b n=%0d want 0/2", ERR_TMO, log_n); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int nb;
    log_n = 0;
    load(0, 8'h30, 4);
    wait_strobes(2, ok);
    for (int t = 0; t < 20 && !TX_BUSY; t++) tick();
    tick();
    n_cmp++; if (ARB_BUSY !== 1'b1 || GRANT !== 4'b0001) begin n_bad++;
      $display("FAIL mid_pre got %b/%b want 1/0001", ARB_BUSY, GRANT); end
    RST = 1'b0;
    for (int i = 0; i < 4; i++) rq_len[i] = 0;
    #1;
    n_cmp++; if (GRANT !== 4'b0 || REQ_READY !== 4'b0) begin n_bad++;
      $display("FAIL mid_rst_gr got %b/%b want 0000/0000", GRANT, REQ_READY); end
    n_cmp++; if (TX_DATA !== 8'h00 || TX_DATA_VALID !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_rst_tx got %h/%b want 00/0", TX_DATA, TX_DATA_VALID); end
    n_cmp++; if (ARB_BUSY !== 1'b0 || ERR_TMO !== 1'b0) begin n_bad++;
      $display("FAIL mid_rst_st got %b/%b want 0/0", ARB_BUSY, ERR_TMO); end
    tick(); RST = 1'b1;
    nb = log_n;
    repeat (20) tick();
    n_cmp++; if (log_n !== nb || ARB_BUSY !== 1'b0) begin n_bad++;
      $display("FAIL mid_quiet got n=%0d busy=%b want %0d/0", log_n, ARB_BUSY, nb); end
    wait_idle(ok);
    load(1, 8'h40, 1);
    wait_strobes(nb + 1, ok);
    n_cmp++; if (!ok || log_d[nb] !== 8'h40 || log_g[nb] !== 4'b0010) begin
      n_bad++;
      $display("FAIL mid_new got %h/%b want 40/0010", log_d[nb], log_g[nb]); end
    wait_idle(ok);
  endtask

  task automatic test_timeout();
    bit ok;
    int k;
    tx_mode = 1;
    log_n = 0;
    load(0, 8'h77, 1);
    k = 0;
    while (!TX_DATA_VALID && k < 20) begin
      tick(); k++;
    end
    n_cmp++; if (TX_DATA_VALID !== 1'b1) begin n_bad++;
      $display("FAIL tmo_strobe got %b want 1", TX_DATA_VALID); end
    k = 0;
    while (ERR_TMO !== 1'b1 && k < 20) begin
      tick(); k++;
    end
    n_cmp++; if (k !== 3) begin n_bad++;
      $display("FAIL tmo_delay got %0d want 3", k); end
    n_cmp++; if (ARB_BUSY !== 1'b0 || GRANT !== 4'b0) begin n_bad++;
      $display("FAIL tmo_idle got %b/%b want 0/0000", ARB_BUSY, GRANT); end
    tx_mode = 0;
    tick();
    load(1, 8'h78, 1);
    wait_strobes(2, ok);
    n_cmp++; if (!ok || log_d[1] !== 8'h78 || log_g[1] !== 4'b0010) begin
      n_bad++;
      $display("FAIL tmo_next got %h/%b want 78/0010", log_d[1], log_g[1]); end
    wait_idle(ok);
    n_cmp++; if (ERR_TMO !== 1'b1) begin n_bad++;
      $display("FAIL tmo_sticky got %b want 1", ERR_TMO); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_single_frame();
    test_rr_all();
    test_burst();
    test_drop();
    test_reset_mid();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
